ex_stage: RTL and testbench



---
 rtl/ex_stage.sv | 140 ++++++++++++++
 tb/tb_ex_stage.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU control decode, operand select, ALU, branch target,
// with all results captured in the EX/MEM output register.
module ex_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [WIDTH-1:0] sign_ext,
  input  logic [WIDTH-1:0] pc,
  input  logic             ALUSrc,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       funct,
  output logic [WIDTH-1:0] address,
  output logic             zero,
  output logic [WIDTH-1:0] resultOut,
  output logic [WIDTH-1:0] pcout
);

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_NONE
  } alu_op_e;

  function automatic alu_op_e alu_decode(input logic [1:0] op, input logic [5:0] fn);
    alu_op_e sel;
    sel = ALU_NONE;
    case (op)
      2'b00: sel = ALU_ADD;
      2'b01: sel = ALU_SUB;
      2'b11: sel = ALU_SLT;
      default: begin
        case (fn)
          6'b100000, 6'b100001: sel = ALU_ADD;
          6'b100010, 6'b100011: sel = ALU_SUB;
          6'b100100:            sel = ALU_AND;
          6'b100101:            sel = ALU_OR;
          6'b100110:            sel = ALU_XOR;
          6'b100111:            sel = ALU_NOR;
          6'b101010:            sel = ALU_SLT;
          6'b101011:            sel = ALU_SLTU;
          6'b000000:            sel = ALU_SLL;
          6'b000010:            sel = ALU_SRL;
          6'b000011:            sel = ALU_SRA;
          default:              sel = ALU_NONE;
        endcase
      end
    endcase
    return sel;
  endfunction

  // Compare results are a single LSB set; everything above is zero-filled.
  function automatic logic [WIDTH-1:0] flag_word(input logic f);
    logic [WIDTH-1:0] w;
    w = '0;
    w[0] = f;
    return w;
  endfunction

  function automatic logic [WIDTH-1:0] alu_eval(
    input alu_op_e          sel,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [4:0]       sh
  );
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [WIDTH-1:0]        r;
    a_s = a;
    b_s = b;
    r   = '0;
    case (sel)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~(a | b);
      ALU_SLT:  r = flag_word(a_s < b_s);
      ALU_SLTU: r = flag_word(a < b);
      ALU_SLL:  r = b << sh;
      ALU_SRL:  r = b >> sh;
      ALU_SRA:  r = b_s >>> sh;
      default:  r = '0;
    endcase
    return r;
  endfunction

  alu_op_e          alu_sel;
  logic [WIDTH-1:0] op_b;
  logic [4:0]       shamt;

  logic [WIDTH-1:0] address_d,   address_q;
  logic             zero_d,      zero_q;
  logic [WIDTH-1:0] result_d,    result_q;
  logic [WIDTH-1:0] pcout_d,     pcout_q;

  // EX stage: operand select, ALU and branch target (combinational)
  always_comb begin
    alu_sel   = alu_decode(ALUOp, funct);
    op_b      = ALUSrc ? sign_ext : rt;
    shamt     = sign_ext[10:6];
    result_d  = alu_eval(alu_sel, rs, op_b, shamt);
    zero_d    = (result_d == '0);
    address_d = pc + (sign_ext << 2);
    pcout_d   = pc;
  end

  // EX/MEM boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address_q <= '0;
      zero_q    <= 1'b0;
      result_q  <= '0;
      pcout_q   <= '0;
    end else begin
      address_q <= address_d;
      zero_q    <= zero_d;
      result_q  <= result_d;
      pcout_q   <= pcout_d;
    end
  end

  assign address   = address_q;
  assign zero      = zero_q;
  assign resultOut = result_q;
  assign pcout     = pcout_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage with hand-computed expected values.
module tb_ex_stage;

  logic        clk;
  logic        reset;
  logic [31:0] rs, rt, sign_ext, pc;
  logic        ALUSrc;
  logic [1:0]  ALUOp;
  logic [5:0]  funct;
  logic [31:0] address, resultOut, pcout;
  logic        zero;

  int n_vec = 0;
  int n_err = 0;

  ex_stage #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .rs(rs), .rt(rt), .sign_ext(sign_ext), .pc(pc),
    .ALUSrc(ALUSrc), .ALUOp(ALUOp), .funct(funct),
    .address(address), .zero(zero), .resultOut(resultOut), .pcout(pcout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one instruction, let it through one rising edge, then sample at edge+1.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] se,
                       input logic [31:0] p, input logic src, input logic [1:0] op,
                       input logic [5:0] fn);
    rs = a; rt = b; sign_ext = se; pc = p; ALUSrc = src; ALUOp = op; funct = fn;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #10;
    n_vec++; if (address !== 32'd0) begin n_err++; $display("FAIL reset_address: got %h want %h", address, 32'd0); end
    n_vec++; if (zero !== 1'b0) begin n_err++; $display("FAIL reset_zero: got %b want %b", zero, 1'b0); end
    n_vec++; if (resultOut !== 32'd0) begin n_err++; $display("FAIL reset_result: got %h want %h", resultOut, 32'd0); end
    n_vec++; if (pcout !== 32'd0) begin n_err++; $display("FAIL reset_pcout: got %h want %h", pcout, 32'd0); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_sll;
    drive(32'd5, 32'd3, 32'd6, 32'd4, 1'b0, 2'b10, 6'b000000);
    n_vec++; if (resultOut !== 32'd3) begin n_err++; $display("FAIL sll_result: got %h want %h", resultOut, 32'd3); end
    n_vec++; if (zero !== 1'b0) begin n_err++; $display("FAIL sll_zero: got %b want %b", zero, 1'b0); end
    n_vec++; if (address !== 32'd28) begin n_err++; $display("FAIL sll_address: got %0d want %0d", address, 28); end
    n_vec++; if (pcout !== 32'd4) begin n_err++; $display("FAIL sll_pcout: got %0d want %0d", pcout, 4); end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [5:0]  fn;
    logic [31:0] res;
    logic        z;
  } rvec_t;

  task automatic test_rtype;
    rvec_t tbl[9];
    tbl[0] = '{32'd5,        6'b100000, 32'd8,          1'b0};
    tbl[1] = '{32'd5,        6'b100010, 32'd2,          1'b0};
    tbl[2] = '{32'd5,        6'b100100, 32'd1,          1'b0};
    tbl[3] = '{32'd5,        6'b100101, 32'd7,          1'b0};
    tbl[4] = '{32'd5,        6'b101010, 32'd0,          1'b1};
    tbl[5] = '{32'hFFFFFFFF, 6'b101011, 32'd0,          1'b1};
    tbl[6] = '{32'hFFFFFFFF, 6'b101010, 32'd1,          1'b0};
    tbl[7] = '{32'd5,        6'b100110, 32'd6,          1'b0};
    tbl[8] = '{32'd5,        6'b100111, 32'hFFFFFFF8,   1'b0};
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].a, 32'd3, 32'd0, 32'd8, 1'b0, 2'b10, tbl[i].fn);
      n_vec++;
      if (resultOut !== tbl[i].res || zero !== tbl[i].z) begin
        n_err++;
        $display("FAIL rtype_%0d funct=%b: got %h/%b want %h/%b", i, tbl[i].fn, resultOut, zero, tbl[i].res, tbl[i].z);
      end
    end
  endtask

  task automatic test_immediate;
    drive(32'd5, 32'd77, 32'hFFFFFFFE, 32'd100, 1'b1, 2'b00, 6'b111111);
    n_vec++; if (resultOut !== 32'd3) begin n_err++; $display("FAIL imm_result: got %h want %h", resultOut, 32'd3); end
    n_vec++; if (address !== 32'd92) begin n_err++; $display("FAIL imm_address: got %0d want %0d", address, 92); end
    n_vec++; if (pcout !== 32'd100) begin n_err++; $display("FAIL imm_pcout: got %0d want %0d", pcout, 100); end
    // slti: -5 < 3 signed
    drive(32'hFFFFFFFB, 32'd0, 32'd3, 32'd0, 1'b1, 2'b11, 6'b000000);
    n_vec++; if (resultOut !== 32'd1) begin n_err++; $display("FAIL slti_result: got %h want %h", resultOut, 32'd1); end
  endtask

  task automatic test_branch;
    drive(32'd7, 32'd7, 32'd0, 32'd0, 1'b0, 2'b01, 6'b000000);
    n_vec++; if (resultOut !== 32'd0 || zero !== 1'b1) begin n_err++; $display("FAIL beq_eq: got %h/%b want %h/%b", resultOut, zero, 32'd0, 1'b1); end
    drive(32'd7, 32'd8, 32'd0, 32'd0, 1'b0, 2'b01, 6'b000000);
    n_vec++; if (resultOut !== 32'hFFFFFFFF || zero !== 1'b0) begin n_err++; $display("FAIL beq_ne: got %h/%b want %h/%b", resultOut, zero, 32'hFFFFFFFF, 1'b0); end
  endtask

  task automatic test_shift_default;
    drive(32'd0, 32'h80000000, 32'h00000100, 32'd0, 1'b0, 2'b10, 6'b000010);
    n_vec++; if (resultOut !== 32'h08000000) begin n_err++; $display("FAIL srl: got %h want %h", resultOut, 32'h08000000); end
    drive(32'd0, 32'h80000000, 32'h00000100, 32'd0, 1'b0, 2'b10, 6'b000011);
    n_vec++; if (resultOut !== 32'hF8000000) begin n_err++; $display("FAIL sra: got %h want %h", resultOut, 32'hF8000000); end
    drive(32'd0, 32'h80000000, 32'h00000100, 32'd0, 1'b0, 2'b10, 6'b111111);
    n_vec++; if (resultOut !== 32'd0 || zero !== 1'b1) begin n_err++; $display("FAIL default_funct: got %h/%b want %h/%b", resultOut, zero, 32'd0, 1'b1); end
  endtask

  task automatic test_back_to_back;
    drive(32'd10, 32'd4, 32'd1, 32'd200, 1'b0, 2'b10, 6'b100001);
    n_vec++; if (resultOut !== 32'd14 || address !== 32'd204) begin n_err++; $display("FAIL b2b_first: got %h/%h want %h/%h", resultOut, address, 32'd14, 32'd204); end
    drive(32'd10, 32'd4, 32'd2, 32'd300, 1'b0, 2'b10, 6'b100011);
    n_vec++; if (resultOut !== 32'd6 || address !== 32'd308 || pcout !== 32'd300) begin n_err++; $display("FAIL b2b_second: got %h/%h/%h want %h/%h/%h", resultOut, address, pcout, 32'd6, 32'd308, 32'd300); end
  endtask

  task automatic test_async_reset;
    drive(32'd9, 32'd1, 32'd4, 32'd40, 1'b0, 2'b00, 6'b000000);
    n_vec++; if (resultOut !== 32'd10 || pcout !== 32'd40) begin n_err++; $display("FAIL pre_reset: got %h/%h want %h/%h", resultOut, pcout, 32'd10, 32'd40); end
    reset = 1'b1;
    #1;
    n_vec++;
    if (resultOut !== 32'd0 || address !== 32'd0 || pcout !== 32'd0 || zero !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got %h/%h/%h/%b want all 0", resultOut, address, pcout, zero);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(32'd2, 32'd2, 32'd0, 32'd12, 1'b0, 2'b01, 6'b000000);
    n_vec++; if (zero !== 1'b1 || pcout !== 32'd12) begin n_err++; $display("FAIL post_reset: got %b/%h want %b/%h", zero, pcout, 1'b1, 32'd12); end
  endtask

  initial begin
    test_reset();
    test_sll();
    test_rtype();
    test_immediate();
    test_branch();
    test_shift_default();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
